// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
// Optional macro CTRL_UPPER_IMM_EN adds LUI/AUIPC support.
module multicycle_control #(
  parameter int OPCODE_WIDTH = 7,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] inst_opcode,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    iord,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    branch,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              ALUOp,
  output logic                    reg_write,
  output logic [1:0]              mem_to_reg,
  output logic                    illegal,
  output logic [2:0]              state,
  output logic [CNT_WIDTH-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_RSV5 = 3'd5, S_RSV6 = 3'd6, S_TRAP = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_R, K_ADDI, K_LW, K_S, K_B, K_J, K_LUI, K_AUIPC
  } kind_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_R     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_S     = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_B     = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(7'b1101111);
`ifdef CTRL_UPPER_IMM_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC = OPCODE_WIDTH'(7'b0010111);
`endif

  state_t                  st, st_n;
  kind_t                   kind;
  logic                    legal;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic                    illegal_q;
  logic                    ld_op, retire;
  logic                    ir_w, pc_w, rw, we, br;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_FETCH;
      op_q      <= '0;
      retired   <= '0;
      illegal_q <= 1'b0;
    end else begin
      st <= st_n;
      if (ld_op)            op_q      <= inst_opcode;
      if (retire)           retired   <= retired + CNT_WIDTH'(1);
      if (st_n == S_TRAP)   illegal_q <= 1'b1;
    end
  end

  // Instruction class of the latched opcode; anything unlisted is illegal.
  always_comb begin
    legal = 1'b1;
    kind  = K_R;
    case (op_q)
      OP_R:     kind = K_R;
      OP_ADDI:  kind = K_ADDI;
      OP_LW:    kind = K_LW;
      OP_S:     kind = K_S;
      OP_B:     kind = K_B;
      OP_J:     kind = K_J;
`ifdef CTRL_UPPER_IMM_EN
      OP_LUI:   kind = K_LUI;
      OP_AUIPC: kind = K_AUIPC;
`endif
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    st_n       = st;
    mem_req    = 1'b0;
    iord       = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    rw         = 1'b0;
    we         = 1'b0;
    br         = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    ALUOp      = 2'b00;
    mem_to_reg = 2'd0;
    ld_op      = 1'b0;
    retire     = 1'b0;
    case (st)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_w  = 1'b1;
          pc_w  = 1'b1;
          ld_op = 1'b1;
          st_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        st_n      = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (!legal) st_n = S_TRAP;
        else begin
          case (kind)
            K_R:    begin alu_src_a = 2'd2; ALUOp = 2'b10; st_n = S_WB; end
            K_ADDI: begin alu_src_a = 2'd2; alu_src_b = 2'd2; ALUOp = 2'b10; st_n = S_WB; end
            K_LW, K_S: begin alu_src_a = 2'd2; alu_src_b = 2'd2; st_n = S_MEM; end
            K_B: begin
              alu_src_a = 2'd2; ALUOp = 2'b01; br = 1'b1; retire = 1'b1; st_n = S_FETCH;
            end
            K_J: begin
              pc_w = 1'b1; rw = 1'b1; mem_to_reg = 2'd2; retire = 1'b1; st_n = S_FETCH;
            end
`ifdef CTRL_UPPER_IMM_EN
            K_LUI:   begin alu_src_a = 2'd3; alu_src_b = 2'd2; st_n = S_WB; end
            K_AUIPC: begin alu_src_a = 2'd1; alu_src_b = 2'd2; st_n = S_WB; end
`endif
            default: st_n = S_TRAP;
          endcase
        end
      end
      S_MEM: begin
        // Request, address source and store enable stay put for the whole wait.
        mem_req = 1'b1;
        iord    = 1'b1;
        we      = (kind == K_S);
        if (mem_ready) begin
          retire = (kind == K_S);
          st_n   = (kind == K_S) ? S_FETCH : (kind == K_LW) ? S_WB : S_TRAP;
        end
      end
      S_WB: begin
        rw         = 1'b1;
        mem_to_reg = (kind == K_LW) ? 2'd1 : 2'd0;
        retire     = 1'b1;
        st_n       = S_FETCH;
      end
      S_TRAP:  st_n = S_TRAP;
      default: st_n = S_TRAP;
    endcase
  end

  // Write enables are masked while reset is held, independent of state.
  assign ir_write  = ir_w & ~rst;
  assign pc_write  = pc_w & ~rst;
  assign reg_write = rw & ~rst;
  assign mem_we    = we & ~rst;
  assign branch    = br & ~rst;
  assign illegal   = illegal_q;
  assign state     = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset corner cases, and a
// random instruction stream checked against an instruction-level trace model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  inst_opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, branch, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, ALUOp, mem_to_reg;
  logic [2:0]  state;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.OPCODE_WIDTH(7), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // exp layout: {state[2:0], mem_req, iord, {ir,pc,rw,we,br}, illegal, a[1:0], b[1:0], aluop[1:0], m2r[1:0]}
  typedef struct {
    logic        rdy;
    logic [6:0]  opc;
    logic [18:0] exp;
    logic [18:0] msk;
    int          ret;
  } cyc_t;

  localparam logic [6:0] OR = 7'b0110011, OADDI = 7'b0010011, OLW = 7'b0000011;
  localparam logic [6:0] OS = 7'b0100011, OB = 7'b1100011, OJ = 7'b1101111;
  localparam logic [6:0] OLUI = 7'b0110111, OAUIPC = 7'b0010111, JNK = 7'h7F;
  localparam logic [7:0] MF = 8'b00_01_00_00, MD = 8'b01_10_00_00;
  localparam logic [7:0] KF = 8'hFC, KW = 8'h03;

  cyc_t tbl[$];
  cyc_t tr[$];

  function automatic cyc_t tv(logic rdy, logic [6:0] opc, logic [2:0] st, logic req,
                              logic io, logic [4:0] en, logic ill, int ret,
                              logic [7:0] mux, logic [7:0] mm);
    cyc_t c;
    c.rdy = rdy;
    c.opc = opc;
    c.exp = {st, req, io, en, ill, mux};
    c.msk = {11'h7FF, mm};
    c.ret = ret;
    return c;
  endfunction

  function automatic logic [18:0] obs();
    return {state, mem_req, iord, ir_write, pc_write, reg_write, mem_we, branch, illegal,
            alu_src_a, alu_src_b, ALUOp, mem_to_reg};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance past the edge.
  task automatic run(input cyc_t c, input string nm);
    mem_ready   = c.rdy;
    inst_opcode = c.opc;
    @(negedge clk);
    cmp({nm, ".out"}, 32'(obs() & c.msk), 32'(c.exp & c.msk));
    cmp({nm, ".ret"}, retired, 32'(c.ret));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1; inst_opcode = OR;
    @(posedge clk); #1;
    @(negedge clk);
    cmp("rst.state", 32'(state), 32'd0);
    cmp("rst.en", 32'({ir_write, pc_write, reg_write, mem_we, branch}), 32'd0);
    cmp("rst.ill", 32'(illegal), 32'd0);
    cmp("rst.ret", retired, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Instruction class from the ISA opcode table; -1 means trap.
  function automatic int kind_of(logic [6:0] op);
    case (op)
      OR: return 0;  OADDI: return 1;  OLW: return 2;
      OS: return 3;  OB:    return 4;  OJ:  return 5;
`ifdef CTRL_UPPER_IMM_EN
      OLUI: return 6; OAUIPC: return 7;
`endif
      default: return -1;
    endcase
  endfunction

  // Expand one instruction into its expected per-cycle trace.
  task automatic add_instr(input logic [6:0] op, input int wf, input int wm, inout int ret);
    int k;
    logic [7:0] mx;
    k = kind_of(op);
    for (int w = 0; w < wf; w++) tr.push_back(tv(0, 7'($urandom), 0, 1, 0, 0, 0, ret, MF, KF));
    tr.push_back(tv(1, op, 0, 1, 0, 5'b11000, 0, ret, MF, KF));
    tr.push_back(tv(1'($urandom), 7'($urandom), 1, 0, 0, 0, 0, ret, MD, KF));
    if (k < 0) begin
      for (int t = 0; t < 5; t++) tr.push_back(tv(1'($urandom), 7'($urandom), 7, 0, 0, 0, 1, ret, 0, 0));
      return;
    end
    case (k)
      0: mx = 8'b10_00_10_00;
      1: mx = 8'b10_10_10_00;
      2, 3: mx = 8'b10_10_00_00;
      4: mx = 8'b10_00_01_00;
      6: mx = 8'b11_10_00_00;
      7: mx = 8'b01_10_00_00;
      default: mx = 8'h00;
    endcase
    if (k == 5) tr.push_back(tv(1'($urandom), 7'($urandom), 2, 0, 0, 5'b01100, 0, ret, 8'b00_00_00_10, KW));
    else tr.push_back(tv(1'($urandom), 7'($urandom), 2, 0, 0, (k == 4) ? 5'b00001 : 5'b0, 0, ret, mx, KF));
    if (k == 2 || k == 3) begin
      for (int w = 0; w <= wm; w++)
        tr.push_back(tv((w == wm), 7'($urandom), 3, 1, 1, (k == 3) ? 5'b00010 : 5'b0, 0, ret, 0, 0));
    end
    if (k != 3 && k != 4 && k != 5)
      tr.push_back(tv(1'($urandom), 7'($urandom), 4, 0, 0, 5'b00100, 0, ret, (k == 2) ? 8'h01 : 8'h00, KW));
    ret++;
  endtask

  initial begin
    int ret;
    logic [6:0] legal_ops[$];

    // R, lw with 3-cycle memory wait, S, B, J, then an illegal opcode.
    tbl.push_back(tv(1, OR,  0, 1, 0, 5'b11000, 0, 0, MF, KF));
    tbl.push_back(tv(1, JNK, 1, 0, 0, 0, 0, 0, MD, KF));
    tbl.push_back(tv(1, JNK, 2, 0, 0, 0, 0, 0, 8'b10_00_10_00, KF));
    tbl.push_back(tv(1, JNK, 4, 0, 0, 5'b00100, 0, 0, 8'h00, KW));
    tbl.push_back(tv(1, OLW, 0, 1, 0, 5'b11000, 0, 1, MF, KF));
    tbl.push_back(tv(1, JNK, 1, 0, 0, 0, 0, 1, MD, KF));
    tbl.push_back(tv(1, JNK, 2, 0, 0, 0, 0, 1, 8'b10_10_00_00, KF));
    tbl.push_back(tv(0, JNK, 3, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(tv(0, JNK, 3, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(tv(0, JNK, 3, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, JNK, 3, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, JNK, 4, 0, 0, 5'b00100, 0, 1, 8'h01, KW));
    tbl.push_back(tv(1, OS,  0, 1, 0, 5'b11000, 0, 2, MF, KF));
    tbl.push_back(tv(1, JNK, 1, 0, 0, 0, 0, 2, MD, KF));
    tbl.push_back(tv(1, JNK, 2, 0, 0, 0, 0, 2, 8'b10_10_00_00, KF));
    tbl.push_back(tv(1, JNK, 3, 1, 1, 5'b00010, 0, 2, 0, 0));
    tbl.push_back(tv(1, OB,  0, 1, 0, 5'b11000, 0, 3, MF, KF));
    tbl.push_back(tv(1, JNK, 1, 0, 0, 0, 0, 3, MD, KF));
    tbl.push_back(tv(1, JNK, 2, 0, 0, 5'b00001, 0, 3, 8'b10_00_01_00, KF));
    tbl.push_back(tv(1, OJ,  0, 1, 0, 5'b11000, 0, 4, MF, KF));
    tbl.push_back(tv(1, JNK, 1, 0, 0, 0, 0, 4, MD, KF));
    tbl.push_back(tv(1, JNK, 2, 0, 0, 5'b01100, 0, 4, 8'b00_00_00_10, KW));
    tbl.push_back(tv(1, JNK, 0, 1, 0, 5'b11000, 0, 5, MF, KF));
    tbl.push_back(tv(1, JNK, 1, 0, 0, 0, 0, 5, MD, KF));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec[%0d]", i));
    for (int i = 0; i < 10; i++)
      run(tv(1'($urandom), 7'($urandom), 7, 0, 0, 0, 1, 5, 0, 0), $sformatf("trap[%0d]", i));
    rst = 1'b1; #1;
    cmp("trap_rst.state", 32'(state), 32'd0);
    cmp("trap_rst.ill", 32'(illegal), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Reset in the middle of a load's memory wait.
    do_reset();
    run(tv(1, OR, 0, 1, 0, 5'b11000, 0, 0, MF, KF), "mw.f0");
    run(tv(1, JNK, 1, 0, 0, 0, 0, 0, MD, KF), "mw.d0");
    run(tv(1, JNK, 2, 0, 0, 0, 0, 0, 8'b10_00_10_00, KF), "mw.e0");
    run(tv(1, JNK, 4, 0, 0, 5'b00100, 0, 0, 8'h00, KW), "mw.w0");
    run(tv(1, OLW, 0, 1, 0, 5'b11000, 0, 1, MF, KF), "mw.f1");
    run(tv(1, JNK, 1, 0, 0, 0, 0, 1, MD, KF), "mw.d1");
    run(tv(1, JNK, 2, 0, 0, 0, 0, 1, 8'b10_10_00_00, KF), "mw.e1");
    run(tv(0, JNK, 3, 1, 1, 0, 0, 1, 0, 0), "mw.m1");
    rst = 1'b1; mem_ready = 1'b1; #1;
    cmp("mw_rst.state", 32'(state), 32'd0);
    cmp("mw_rst.ret", retired, 32'd0);
    cmp("mw_rst.en", 32'({ir_write, pc_write, reg_write, mem_we, branch}), 32'd0);
    @(negedge clk);
    cmp("mw_rst.en2", 32'({ir_write, pc_write, reg_write, mem_we, branch}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // LUI: legal only with the upper-immediate option.
    do_reset();
    run(tv(1, OLUI, 0, 1, 0, 5'b11000, 0, 0, MF, KF), "lui.f");
    run(tv(1, JNK, 1, 0, 0, 0, 0, 0, MD, KF), "lui.d");
`ifdef CTRL_UPPER_IMM_EN
    run(tv(1, JNK, 2, 0, 0, 0, 0, 0, 8'b11_10_00_00, KF), "lui.e");
    run(tv(1, JNK, 4, 0, 0, 5'b00100, 0, 0, 8'h00, KW), "lui.w");
    run(tv(0, JNK, 0, 1, 0, 0, 0, 1, MF, KF), "lui.next");
`else
    run(tv(1, JNK, 7, 0, 0, 0, 1, 0, 0, 0), "lui.trap0");
    run(tv(1, JNK, 7, 0, 0, 0, 1, 0, 0, 0), "lui.trap1");
`endif

    // Random instruction stream with random memory latencies.
    legal_ops = '{OR, OADDI, OLW, OS, OB, OJ};
`ifdef CTRL_UPPER_IMM_EN
    legal_ops.push_back(OLUI);
    legal_ops.push_back(OAUIPC);
`endif
    do_reset();
    ret = 0;
    for (int n = 0; n < 40; n++)
      add_instr(legal_ops[$urandom % legal_ops.size()], $urandom % 3, $urandom % 4, ret);
    add_instr(7'b1111111, $urandom % 3, 0, ret);
    for (int i = 0; i < tr.size(); i++) run(tr[i], $sformatf("rand[%0d]", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
